instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters SHALL be: DEPTH, default 2, prefetch queue entries; RESET_PC, default 32'h0, first fetch address; PC_STEP, default 4, byte increment per word.
REQ-002 Port clock  in  1  rising-edge system clock.
REQ-003 Port reset  in  1  asynchronous, active-low reset.
REQ-004 Port redirect  in  1  one-cycle pulse that flushes the queue and restarts fetch at redirect_pc.
REQ-005 Port redirect_pc  in  32  new fetch byte address.
REQ-006 Port ir_valid  out  1  queue head holds a valid instruction.
REQ-007 Port ir  out  32  instruction word at queue head.
REQ-008 Port ir_pc  out  32  byte address of ir.
REQ-009 Port ir_ready  in  1  decode stage accepts the head this cycle.
REQ-010 Port m_en  out  1  memory request active.
REQ-011 Port m_rw  out  1  constant 1 (read).
REQ-012 Port mar  out  32  request byte address.
REQ-013 Port mem_ack  in  1  memory returns dbus for the current request.
REQ-014 Port dbus  in  32  big-endian word {m[a],m[a+1],m[a+2],m[a+3]}.

Function
REQ-015 All outputs SHALL be registered or driven directly from registered state.
REQ-016 FSM states SHALL be IDLE, REQ and DROP; at most one memory request outstanding.
REQ-017 IDLE->REQ when count < DEPTH and redirect=0; on that edge m_en<=1, mar<=pc.
REQ-018 In REQ and DROP, m_en and mar SHALL hold constant until the edge where mem_ack=1.
REQ-019 REQ with mem_ack=1 and redirect=0: push {dbus, mar}, pc<=pc+PC_STEP, m_en<=0, go IDLE.
REQ-020 REQ with redirect=1 and mem_ack=0: go DROP; the pending reply is discarded on arrival.
REQ-021 REQ with redirect=1 and mem_ack=1 in the same cycle: discard dbus, go IDLE.
REQ-022 DROP with mem_ack=1: discard dbus, m_en<=0, go IDLE; a further redirect in DROP only updates pc.
REQ-023 Redirect SHALL empty the queue, set pc<=redirect_pc with bits[1:0] forced to 0, and take priority over any pop or push that cycle.
REQ-024 Pop SHALL occur on an edge with ir_valid=1, ir_ready=1 and redirect=0; ir_ready with ir_valid=0 is ignored.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; push never overflows because issue requires count < DEPTH.
REQ-026 ir_valid = (count != 0); ir and ir_pc are stable while ir_valid=1 and not popped.
REQ-027 pc arithmetic SHALL be modulo 2^32 (32'hFFFFFFFC + 4 = 32'h0).
REQ-028 Best-case latency: m_en high on edge N, mem_ack high in that cycle, ir_valid high after edge N+1.

Reset
REQ-029 reset=0 SHALL immediately force: state IDLE, count 0, pc RESET_PC, m_en 0, m_rw 1, mar 0, ir_valid 0, ir 0, ir_pc 0.
REQ-030 Reset during REQ/DROP SHALL abandon the request; a late mem_ack after release SHALL be ignored in IDLE.
REQ-031 The first request SHALL issue on the first rising edge after reset returns to 1.

Structure
REQ-032 Shared package cpu0_pkg SHALL hold the fetch state enum, RESET_PC and PC_STEP defaults, and the LD/ST/ADD/JMP opcode constants.
REQ-033 The queue SHALL be a sub-module fetch_fifo (DEPTH x 64 bits {ir_pc, ir}, push/pop/flush, count).

Verification
REQ-034 Reset release, memory acks same cycle with program 001F0018, 002F0010, 003F0014 -> ir/ir_pc = 001F0018/0, 002F0010/4, 003F0014/8 in order.
REQ-035 ir_ready held 0 -> exactly 2 words queued, m_en stays 0, mar not advanced beyond 8; raising ir_ready resumes fetch at 8.
REQ-036 Redirect to 32'h0000000E during REQ with mem_ack delayed 3 cycles -> DROP entered, delayed reply discarded, next mar = 32'h0000000C, queue empty until it returns.
REQ-037 Redirect and mem_ack in same cycle, plus ir_ready=1 -> no push, no pop, count 0, next request at redirect_pc.
REQ-038 redirect_pc = 32'hFFFFFFFC -> fetches at FFFFFFFC then 00000000.
REQ-039 Assert reset mid-REQ, ack one cycle after release -> ack ignored, new request at RESET_PC, no spurious ir_valid.

Source files
------------

// File: rtl/cpu0_pkg.sv
// cpu0 shared definitions: fetch FSM states, fetch defaults,
// queue entry layout and the base opcode constants.
package cpu0_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

   localparam logic [7:0] OP_LD  = 8'h00;
   localparam logic [7:0] OP_ST  = 8'h01;
   localparam logic [7:0] OP_ADD = 8'h02;
   localparam logic [7:0] OP_JMP = 8'h03;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
   } fetch_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] a);
      return a & ~32'h3;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: head always sits in slot 0, pop shifts down,
// flush just clears the count (stale slots are never exposed).
module fetch_fifo
   import cpu0_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_entry_t  din,
   output fetch_entry_t  head,
   output logic [CW-1:0] count
);

   fetch_entry_t  mem [DEPTH];
   logic [CW-1:0] wr_idx;

   assign wr_idx = pop ? count - CW'(1) : count;
   assign head   = mem[0];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (pop) mem[i] <= mem[i+1];
         end
         // later write wins over the shift when both hit a slot
         for (int i = 0; i < DEPTH; i++) begin
            if (push && wr_idx == CW'(i)) mem[i] <= din;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding read, redirect flush,
// DROP state swallows the reply of an abandoned request.
module instr_fetch
   import cpu0_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        ir_valid,
   output logic [31:0] ir,
   output logic [31:0] ir_pc,
   input  logic        ir_ready,
   output logic        m_en,
   output logic        m_rw,
   output logic [31:0] mar,
   input  logic        mem_ack,
   input  logic [31:0] dbus
);

   localparam int CW = $clog2(DEPTH + 1);

   fetch_state_e  state_q;
   fetch_state_e  state_d;
   logic [31:0]   pc_q;
   logic [31:0]   pc_d;
   logic [31:0]   mar_d;
   logic          m_en_d;
   logic          push;
   logic          pop;
   logic          can_issue;
   logic [CW-1:0] count;
   fetch_entry_t  head;
   fetch_entry_t  din;

   assign can_issue = count < CW'(DEPTH);
   assign pop       = ir_valid & ir_ready & ~redirect;
   assign din       = '{pc: mar, ir: dbus};

   assign ir_valid = count != '0;
   assign ir       = head.ir;
   assign ir_pc    = head.pc;
   assign m_rw     = 1'b1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!redirect && can_issue) state_d = REQ;
         REQ: begin
            if (mem_ack)       state_d = IDLE;
            else if (redirect) state_d = DROP;
         end
         DROP:    if (mem_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      push   = 1'b0;
      pc_d   = pc_q;
      m_en_d = m_en;
      mar_d  = mar;
      unique case (state_q)
         IDLE: begin
            if (!redirect && can_issue) begin
               m_en_d = 1'b1;
               mar_d  = pc_q;
            end
         end
         REQ: begin
            if (mem_ack) begin
               m_en_d = 1'b0;
               if (!redirect) begin
                  push = 1'b1;
                  pc_d = pc_q + PC_STEP;
               end
            end
         end
         DROP:    if (mem_ack) m_en_d = 1'b0;
         default: ;
      endcase
      if (redirect) pc_d = align_word(redirect_pc);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q <= RESET_PC;
         m_en <= 1'b0;
         mar  <= '0;
      end else begin
         pc_q <= pc_d;
         m_en <= m_en_d;
         mar  <= mar_d;
      end
   end

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clock(clock),
      .reset(reset),
      .push (push),
      .pop  (pop),
      .flush(redirect),
      .din  (din),
      .head (head),
      .count(count)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic,
// all checked against a transaction-level fetch-stream model.
module tb_instr_fetch;

   localparam int DEPTH = 2;
   localparam logic [31:0] RST_PC = 32'h0;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        ir_valid;
   logic [31:0] ir;
   logic [31:0] ir_pc;
   logic        ir_ready = 1'b0;
   logic        m_en;
   logic        m_rw;
   logic [31:0] mar;
   logic        mem_ack = 1'b0;
   logic [31:0] dbus;

   int checks = 0;
   int failures = 0;

   logic [31:0] q[$];
   logic        busy;
   logic        stale;
   logic [31:0] next_pc;
   logic [31:0] cur_addr;

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h001F_0018;
         32'h4:   return 32'h002F_0010;
         32'h8:   return 32'h003F_0014;
         default: return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
      endcase
   endfunction

   assign dbus = mem_word(mar);

   instr_fetch #(
      .DEPTH   (DEPTH),
      .RESET_PC(RST_PC),
      .PC_STEP (32'd4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .ir_valid   (ir_valid),
      .ir         (ir),
      .ir_pc      (ir_pc),
      .ir_ready   (ir_ready),
      .m_en       (m_en),
      .m_rw       (m_rw),
      .mar        (mar),
      .mem_ack    (mem_ack),
      .dbus       (dbus)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      busy = 1'b0;
      stale = 1'b0;
      next_pc = RST_PC;
      cur_addr = '0;
   endtask

   // Fetch stream rules: sequential words from next_pc, at most one
   // read in flight, redirect flushes and retargets the stream.
   task automatic model_step(input logic r, input logic [31:0] rp,
                             input logic rdy, input logic ak);
      int  cnt;
      bit  do_pop;
      cnt = q.size();
      do_pop = (cnt != 0) && rdy && !r;
      if (r) begin
         q.delete();
         next_pc = {rp[31:2], 2'b00};
         if (busy) begin
            if (ak) begin
               busy = 1'b0;
               stale = 1'b0;
            end else begin
               stale = 1'b1;
            end
         end
      end else begin
         if (busy) begin
            if (ak) begin
               if (!stale) begin
                  q.push_back(cur_addr);
                  next_pc = next_pc + 32'd4;
               end
               busy = 1'b0;
               stale = 1'b0;
            end
         end else if (cnt < DEPTH) begin
            busy = 1'b1;
            cur_addr = next_pc;
         end
         if (do_pop) void'(q.pop_front());
      end
   endtask

   task automatic check_all();
      chk("ir_valid", 32'(ir_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("ir_pc", ir_pc, q[0]);
         chk("ir", ir, mem_word(q[0]));
      end
      chk("m_en", 32'(m_en), 32'(busy));
      if (busy) chk("mar", mar, cur_addr);
      chk("m_rw", 32'(m_rw), 32'd1);
   endtask

   task automatic reset_check();
      chk("rst_m_en", 32'(m_en), 32'd0);
      chk("rst_m_rw", 32'(m_rw), 32'd1);
      chk("rst_mar", mar, 32'd0);
      chk("rst_ir_valid", 32'(ir_valid), 32'd0);
      chk("rst_ir", ir, 32'd0);
      chk("rst_ir_pc", ir_pc, 32'd0);
   endtask

   // Called on a negedge; returns on the next negedge.
   task automatic cycle(input logic r, input logic [31:0] rp,
                        input logic rdy, input logic ak);
      redirect = r;
      redirect_pc = rp;
      ir_ready = rdy;
      mem_ack = ak;
      @(posedge clock);
      model_step(r, rp, rdy, ak);
      @(negedge clock);
      check_all();
   endtask

   initial begin
      model_reset();
      @(posedge clock);
      @(negedge clock);
      reset_check();
      reset = 1'b1;

      // first request on the first edge after release
      cycle(1'b0, '0, 1'b0, 1'b0);
      chk("first_req_mar", mar, RST_PC);
      chk("first_req_m_en", 32'(m_en), 32'd1);

      // decode stalled: exactly two words queued, fetch parked
      for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b0, 1'b1);
      chk("stall_ir", ir, 32'h001F_0018);
      chk("stall_ir_pc", ir_pc, 32'h0);
      chk("stall_m_en", 32'(m_en), 32'd0);
      chk("stall_mar", mar, 32'h4);
      chk("stall_cnt", 32'(q.size()), 32'd2);

      cycle(1'b0, '0, 1'b1, 1'b1);
      chk("seq_ir1", ir, 32'h002F_0010);
      chk("seq_pc1", ir_pc, 32'h4);
      cycle(1'b0, '0, 1'b1, 1'b1);
      chk("resume_mar", mar, 32'h8);
      cycle(1'b0, '0, 1'b1, 1'b1);
      chk("seq_ir2", ir, 32'h003F_0014);
      chk("seq_pc2", ir_pc, 32'h8);

      // settle to an idle fetcher
      for (int i = 0; i < 10 && busy; i++) cycle(1'b0, '0, 1'b1, 1'b1);
      chk("settle_idle", 32'(busy), 32'd0);

      // redirect while a request is pending, reply late
      cycle(1'b1, 32'h100, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      chk("pre_drop_mar", mar, 32'h100);
      cycle(1'b1, 32'h0000_000E, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      chk("drop_hold_mar", mar, 32'h100);
      chk("drop_hold_m_en", 32'(m_en), 32'd1);
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("drop_discard", 32'(ir_valid), 32'd0);
      chk("drop_m_en", 32'(m_en), 32'd0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      chk("drop_next_mar", mar, 32'hC);
      chk("drop_still_empty", 32'(ir_valid), 32'd0);
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("drop_ret_pc", ir_pc, 32'hC);

      // redirect, ack and ready on the same edge
      cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b1, 32'h40, 1'b1, 1'b1);
      chk("same_cyc_valid", 32'(ir_valid), 32'd0);
      chk("same_cyc_m_en", 32'(m_en), 32'd0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("same_cyc_mar", mar, 32'h40);

      // address wrap
      cycle(1'b0, '0, 1'b0, 1'b1);
      cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      chk("wrap_mar0", mar, 32'hFFFF_FFFC);
      cycle(1'b0, '0, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b0);
      chk("wrap_mar1", mar, 32'h0);
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("wrap_pc0", ir_pc, 32'hFFFF_FFFC);
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("wrap_pc1", ir_pc, 32'h0);

      // reset in the middle of a request, late ack after release
      cycle(1'b0, '0, 1'b0, 1'b0);
      chk("pre_rst_m_en", 32'(m_en), 32'd1);
      redirect = 1'b0;
      ir_ready = 1'b0;
      mem_ack = 1'b0;
      reset = 1'b0;
      #1;
      reset_check();
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("late_ack_mar", mar, RST_PC);
      chk("late_ack_valid", 32'(ir_valid), 32'd0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      chk("late_ack_valid2", 32'(ir_valid), 32'd0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic        r;
         logic [31:0] rp;
         r = ($urandom_range(0, 15) == 0);
         rp = $urandom();
         if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hF);
         cycle(r, rp, ($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
